// File: rtl/mod_mult_pipe.sv
// Multi-lane pipelined modular multiplier, res = (a*b) mod Q per lane, fully reduced.
// Barrett reduction with two trailing corrections so any W-bit operand pair is legal.
module mod_mult_pipe #(
  parameter int unsigned W          = 12,
  parameter int unsigned Q          = 3329,
  parameter int unsigned LANES      = 2,
  parameter int unsigned DSP_STAGES = 3,
  parameter int unsigned TAG_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 valid_in,
  input  logic [TAG_W-1:0]     tag_in,
  input  logic [LANES*W-1:0]   a,
  input  logic [LANES*W-1:0]   b,
  output logic                 valid_out,
  output logic [TAG_W-1:0]     tag_out,
  output logic [LANES*W-1:0]   res
);
  localparam int unsigned K   = 2 * W;
  localparam int unsigned LAT = DSP_STAGES + 4;
  localparam logic [K:0]   TWO_K = {1'b1, {K{1'b0}}};
  localparam logic [K-1:0] M     = K'(TWO_K / (K+1)'(Q));
  localparam logic [W+1:0] QR    = (W+2)'(Q);

  if (Q >= (64'd1 << W) || Q <= 2 || DSP_STAGES < 1) begin : g_bad_param
    $error("mod_mult_pipe: need 2 < Q < 2**W and DSP_STAGES >= 1");
  end

  // Valid and tag ride a plain shift register matching the datapath depth.
  logic [LAT-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0] tag_q [LAT];
  logic [TAG_W-1:0] tag_d [LAT];

  always_comb begin
    valid_d  = {valid_q[LAT-2:0], valid_in};
    tag_d[0] = tag_in;
    for (int i = 1; i < LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else if (en) begin
      valid_q <= valid_d;
      for (int i = 0; i < LAT; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign valid_out = valid_q[LAT-1];
  assign tag_out   = tag_q[LAT-1];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    logic [K-1:0]   p_q [DSP_STAGES];
    logic [K-1:0]   p_d [DSP_STAGES];
    logic [K-1:0]   bp_q, bp_d;
    logic [K-1:0]   t_q, t_d;
    logic [W+1:0]   r_q, r_d;
    logic [W-1:0]   o_q, o_d;
    logic [2*K-1:0] pm;
    logic [W+1:0]   r1;

    always_comb begin
      a_d    = a[gi*W +: W];
      b_d    = b[gi*W +: W];
      p_d[0] = K'(a_q) * K'(b_q);
      for (int i = 1; i < DSP_STAGES; i++) begin
        p_d[i] = p_q[i-1];
      end
      pm   = (2*K)'(p_q[DSP_STAGES-1]) * (2*K)'(M);
      t_d  = K'(pm >> K);
      bp_d = p_q[DSP_STAGES-1];
      // Quotient estimate undershoots by at most 2, so r lands in [0, 3Q) and fits W+2 bits.
      r_d  = (W+2)'(bp_q - t_q * K'(Q));
      r1   = (r_q >= QR) ? (r_q - QR) : r_q;
      o_d  = (r1 >= QR) ? W'(r1 - QR) : W'(r1);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a_q  <= '0;
        b_q  <= '0;
        for (int i = 0; i < DSP_STAGES; i++) begin
          p_q[i] <= '0;
        end
        bp_q <= '0;
        t_q  <= '0;
        r_q  <= '0;
        o_q  <= '0;
      end else if (en) begin
        a_q  <= a_d;
        b_q  <= b_d;
        for (int i = 0; i < DSP_STAGES; i++) begin
          p_q[i] <= p_d[i];
        end
        bp_q <= bp_d;
        t_q  <= t_d;
        r_q  <= r_d;
        o_q  <= o_d;
      end
    end

    assign res[gi*W +: W] = o_q;
  end

endmodule

// File: tb/tb_mod_mult_pipe.sv
// Bench for mod_mult_pipe: latency-queue model of (a*b)%Q checked every cycle,
// plus directed beats with hand-computed results.
module tb_mod_mult_pipe;
  localparam int W = 12, Q = 3329, LANES = 2, DSP = 3, TAG_W = 8;
  localparam int LAT = DSP + 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                en = 1'b0;
  logic                valid_in = 1'b0;
  logic [TAG_W-1:0]    tag_in = '0;
  logic [LANES*W-1:0]  a = '0;
  logic [LANES*W-1:0]  b = '0;
  logic                valid_out;
  logic [TAG_W-1:0]    tag_out;
  logic [LANES*W-1:0]  res;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mod_mult_pipe #(.W(W), .Q(Q), .LANES(LANES), .DSP_STAGES(DSP), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .en(en), .valid_in(valid_in), .tag_in(tag_in),
    .a(a), .b(b), .valid_out(valid_out), .tag_out(tag_out), .res(res)
  );

  typedef struct packed {
    logic              v;
    logic [TAG_W-1:0]  tag;
    logic [LANES*W-1:0] r;
  } beat_t;

  beat_t exp_q[$];

  function automatic logic [LANES*W-1:0] golden(input logic [LANES*W-1:0] x, input logic [LANES*W-1:0] y);
    logic [LANES*W-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      r[i*W +: W] = W'((longint'(x[i*W +: W]) * longint'(y[i*W +: W])) % Q);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Model: the output after an enabled edge is whatever was sampled LAT-1 enabled edges earlier.
  always @(posedge clk) begin
    beat_t nb;
    beat_t e;
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < LAT; i++) exp_q.push_back('0);
    end else if (en) begin
      nb.v   = valid_in;
      nb.tag = tag_in;
      nb.r   = golden(a, b);
      exp_q.push_back(nb);
      void'(exp_q.pop_front());
    end
    #1;
    if (exp_q.size() == LAT) begin
      e = exp_q[0];
      check("cyc_valid", 32'(valid_out), 32'(e.v));
      check("cyc_tag", 32'(tag_out), 32'(e.tag));
      check("cyc_res", 32'(res), 32'(e.r));
    end
  end

  task automatic drive(input logic e, input logic v, input logic [TAG_W-1:0] t,
                       input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input logic [W-1:0] a1, input logic [W-1:0] b1);
    @(negedge clk);
    en = e; valid_in = v; tag_in = t; a = {a1, a0}; b = {b1, b0};
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, '0, '0, '0, '0, '0);
  endtask

  // Sends one beat after idle cycles and checks it appears exactly after the (LAT-1)th edge.
  task automatic directed(input string name, input logic [TAG_W-1:0] t,
                          input logic [W-1:0] a0, input logic [W-1:0] b0,
                          input logic [W-1:0] a1, input logic [W-1:0] b1,
                          input logic [W-1:0] e0, input logic [W-1:0] e1);
    drive(1'b1, 1'b1, t, a0, b0, a1, b1);
    idle();
    repeat (LAT - 2) @(posedge clk);
    #2;
    check({name, "_early_valid"}, 32'(valid_out), 32'd0);
    @(posedge clk);
    #2;
    check({name, "_valid"}, 32'(valid_out), 32'd1);
    check({name, "_tag"}, 32'(tag_out), 32'(t));
    check({name, "_lane0"}, 32'(res[W-1:0]), 32'(e0));
    check({name, "_lane1"}, 32'(res[2*W-1:W]), 32'(e1));
    $display("beat %s tag=0x%0h lane0=%0d lane1=%0d valid=%0b", name, tag_out, res[W-1:0], res[2*W-1:W], valid_out);
  endtask

  initial begin
    logic [W-1:0] ra0, rb0, ra1, rb1;

    check("pin_canon", 32'(golden({12'd0, 12'd3328}, {12'd3328, 12'd3328})), 32'h000_001);
    check("pin_noncanon", 32'(golden({12'd17, 12'd4095}, {12'd2285, 12'd4095})), {8'h00, 12'd2226, 12'd852});

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_tag", 32'(tag_out), 32'd0);
    check("rst_res", 32'(res), 32'd0);
    repeat (20) idle();

    directed("canon", 8'h11, 12'd3328, 12'd3328, 12'd0, 12'd3328, 12'd1, 12'd0);
    directed("noncanon", 8'h22, 12'd4095, 12'd4095, 12'd17, 12'd2285, 12'd852, 12'd2226);
    directed("lane_indep", 8'h33, 12'd4095, 12'd4095, 12'd0, 12'd0, 12'd852, 12'd0);

    // Back-to-back stream with a 5-cycle stall in the middle; beats offered during the stall must vanish.
    for (int i = 0; i < 64; i++) begin
      if (i == 30) begin
        for (int s = 0; s < 5; s++) begin
          ra0 = W'($urandom_range(0, 4095)); rb0 = W'($urandom_range(0, 4095));
          ra1 = W'($urandom_range(0, 4095)); rb1 = W'($urandom_range(0, 4095));
          drive(1'b0, (s % 2) == 0, TAG_W'(8'hF0 + s), ra0, rb0, ra1, rb1);
        end
      end
      ra0 = W'($urandom_range(0, 4095)); rb0 = W'($urandom_range(0, 4095));
      ra1 = W'($urandom_range(0, 4095)); rb1 = W'($urandom_range(0, 4095));
      drive(1'b1, 1'b1, TAG_W'(i), ra0, rb0, ra1, rb1);
    end
    repeat (LAT + 3) idle();

    // Reset with beats in flight: only the post-reset beat may emerge.
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, TAG_W'(8'hA0 + i), 12'd100, 12'd200, 12'd300, 12'd400);
    @(negedge clk);
    rst = 1'b1; valid_in = 1'b0; tag_in = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("midrst_valid", 32'(valid_out), 32'd0);
    check("midrst_res", 32'(res), 32'd0);
    rst = 1'b0;
    directed("after_rst", 8'h55, 12'd2, 12'd1665, 12'd4095, 12'd1, 12'd1, 12'd766);
    repeat (10) idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mod_mult_pipe.md
Name: mod_mult_pipe

Overview:
- Parametrised, multi-lane pipelined modular multiplier for the NTT datapath: res = (a*b) mod Q per lane, always fully reduced to [0, Q-1].
- Successor to the fixed 12-bit single-lane multiplier. Adds:
  - configurable width, modulus and DSP depth;
  - LANES parallel lanes;
  - valid/tag tracking and a global pipeline enable (stall);
  - inline two-correction Barrett reduction, so any W-bit operands are accepted, not only canonical ones.
- Sits between the coefficient/twiddle RAMs and the butterfly add/sub units.

Parameters:
- W, 12, operand/result width per lane.
- Q, 3329, modulus; requires 2 < Q < 2^W.
- LANES, 2, number of independent multiplier lanes sharing control.
- DSP_STAGES, 3, product register stages after the input register (>=1).
- TAG_W, 8, width of the sideband tag carried alongside data (>=1).
- Derived: K = 2*W; M = floor(2^K / Q) (5039 for defaults); LAT = DSP_STAGES + 4.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  global pipeline enable; 0 freezes every stage.
- valid_in  input  1  input beat valid.
- tag_in  input  TAG_W  sideband (e.g. coefficient address) for the beat.
- a  input  LANES*W  packed operands; lane i at [i*W +: W].
- b  input  LANES*W  packed operands, same packing as a.
- valid_out  output  1  result beat valid.
- tag_out  output  TAG_W  tag_in of the beat now on res.
- res  output  LANES*W  packed reduced products, same packing as a.

Behaviour:
- Reset: asynchronous, active-high. While rst=1, every pipeline register is 0, including valid, tag and data. So valid_out=0, tag_out=0, res=0. In-flight beats are discarded; nothing reappears after reset release.
- Pipeline, advancing only on clk edges with en=1:
  - S0: register a, b, valid_in, tag_in.
  - P1..P_DSP_STAGES: P = a*b, exactly 2W bits, registered then delayed.
  - B1: t = (P*M) >> K, registered, together with P.
  - B2: r = P - t*Q, truncated to W+2 bits (true value in [0, 3Q)), registered.
  - B3: r1 = r>=Q ? r-Q : r; out = r1>=Q ? r1-Q : r1. Registered to res.
- Latency: a beat sampled at edge n (en=1) appears on res/valid_out/tag_out after edge n+LAT-1, counting only enabled edges. Default LAT=7.
- Throughput: one beat per enabled cycle; no back-pressure output.
- Valid and tag travel in lockstep with data. Data registers update every enabled cycle even when valid=0; consumers qualify on valid_out.
- en=0: all registers, including valid, hold their values. Outputs stay stable for any number of cycles. Resuming with en=1 continues exactly where it stopped, with no lost or duplicated beats.
- en=0 on the same edge as valid_in=1: the beat is not sampled.
- Lanes are independent and share valid/tag/en. One lane's data never affects another's result.
- Operands >= Q (up to 2^W-1) are legal and reduce correctly. The two correction subtractions are mandatory.
- Arithmetic is unsigned throughout. No signed or Montgomery representation.
- Elaboration check: error out if Q >= 2^W or DSP_STAGES < 1.

Test Plan:
- Reset then idle: hold rst 3 cycles, release with valid_in=0 -> valid_out=0, res=0, tag_out=0 for 20 cycles.
- Canonical extremes, lane0 a=3328 b=3328 tag=0x11, lane1 a=0 b=3328 -> exactly 7 cycles later: valid_out=1, tag_out=0x11, lane0=1, lane1=0.
- Non-canonical inputs, lane0 a=4095 b=4095, lane1 a=17 b=2285 -> lane0=852, lane1=2226. Exercises the double correction.
- Back-to-back stream of 64 random beats with incrementing tags, compared against a golden (a*b)%3329 model -> every output matches, in order, with consecutive tags, no gaps.
- Stall: mid-stream drop en for 5 cycles, with valid_in toggling during the stall -> outputs frozen during the stall; after resume the sequence matches the model with no drops or duplicates; beats offered while en=0 never appear.
- Reset mid-operation: assert rst while 4 beats are in flight, release, send one beat a=2 b=1665 -> only that beat emerges, 7 cycles after it is sent, res=1; the earlier beats never appear.
